rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port (WE3/A3/WD3) between the in-order pipeline writeback (primary) and a long-latency unit such as MUL/DIV or load return (secondary). The primary write always gets the port. Secondary results are queued in a small FIFO and drained into idle write cycles. A starvation limit briefly stalls the pipeline so queued results always drain. An optional scoreboard reports registers with pending secondary writes.

## Interface
- WIDTH, 32, data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, secondary queue depth; power of two, ≥2
- STARVE_MAX, 4, max consecutive cycles the FIFO head may wait before a forced grant; ≥1
- clk  in  1  clock
- areset  in  1  asynchronous reset, active-low
- p_we  in  1  primary write request
- p_addr  in  ADDR_W  primary destination
- p_data  in  WIDTH  primary data
- p_stall  out  1  primary must hold its writeback this cycle
- s_valid  in  1  secondary result valid
- s_ready  out  1  secondary result accepted when high with s_valid
- s_addr  in  ADDR_W  secondary destination
- s_data  in  WIDTH  secondary data
- rf_we  out  1  to register file WE3
- rf_addr  out  ADDR_W  to A3
- rf_wdata  out  WIDTH  to WD3
- sb_set  in  1  long-latency op issued; mark sb_set_addr busy
- sb_set_addr  in  ADDR_W  destination of issued op
- rd_addr1, rd_addr2  in  ADDR_W  decode-stage source addresses
- busy1, busy2  out  1  source has a pending secondary write

## Operation
- FIFO push: s_valid & s_ready. s_ready = (count < FIFO_DEPTH). It does not depend on a same-cycle pop.
- Writes with address 0 are discarded. A primary x0 write produces no rf_we. A secondary x0 write is accepted, handshaken and dropped without a push.
- Grant per cycle, evaluated in priority order:
  - If p_stall is high: FIFO head is granted. p_we is ignored and the pipeline re-presents the write next cycle.
  - Else if p_we and p_addr≠0: primary is granted.
  - Else if FIFO is not empty: FIFO head is granted and popped.
  - Else: no write.
- Starvation counter starve_cnt:
  - Clears to 0 on any secondary grant or when the FIFO is empty.
  - Otherwise increments when the FIFO is non-empty and the head was not granted. Saturates at STARVE_MAX.
  - p_stall = (starve_cnt == STARVE_MAX) & FIFO non-empty. It is combinational from registered state.
- Same address in the primary and the FIFO head in one cycle: primary writes first and the secondary writes later. WAW ordering is the scoreboard user's responsibility. This block performs no address compare.

## Timing
- Granted write appears on rf_we/rf_addr/rf_wdata at the next rising edge. Outputs are registered, so latency is 1 cycle.
- Secondary best case: push at edge N, grant in cycle N+1, rf_we in cycle N+2.
- Worst-case wait of the FIFO head under continuous primary traffic: STARVE_MAX cycles plus 1 forced cycle.
- Reset (areset low, asynchronous):
  - rf_we=0, rf_addr=0, rf_wdata=0.
  - FIFO empty, so s_ready=1.
  - starve_cnt=0, so p_stall=0.
  - All scoreboard bits clear, so busy1/busy2=0.
  - Queued writes are lost on reset mid-operation.
- One rf_we per cycle at most. The FIFO pointers wrap modulo FIFO_DEPTH. count has ADDR-independent width $clog2(FIFO_DEPTH)+1.

## Configuration
- RF_ARB_SCOREBOARD_EN defined: a 32-bit pending register is compiled in.
  - sb_set sets bit sb_set_addr. Address 0 is never set.
  - A secondary write reaching rf_we clears its bit.
  - If a set and a clear hit the same address in the same cycle, the set wins.
  - busy1 = pending[rd_addr1], busy2 = pending[rd_addr2], both combinational.
- Undefined: the sb_* and rd_addr* inputs are ignored, and busy1/busy2 are tied 0. The ports remain present.

## Structure
- Shared package rv_rf_pkg holds:
  - WIDTH and ADDR_W defaults.
  - REG_X0 constant (0).
  - STARVE_MAX default.
  - A wb_req_t struct {addr, data}.
- One sub-module: rf_wb_fifo, the parameterised synchronous FIFO holding wb_req_t, with count output.
- Arbitration, the starvation counter and the scoreboard stay in the top module.

## Test plan
- Reset check: assert areset mid-stream with 2 entries queued. Required: all outputs 0 and s_ready=1 immediately; the queued entries are never written.
- Idle drain: no primary traffic; push s_addr=5, s_data=0xDEADBEEF at edge N. Required: rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF in cycle N+2.
- Priority: in the same cycle, p_we to x3=0x11 and FIFO head x7=0x22. Required: x3 is written first, x7 the next cycle.
- Backpressure and starvation: continuous p_we, push 2 entries. Required:
  - s_ready=0 while the FIFO is full.
  - p_stall=1 after 4 waiting cycles, and the head is written that cycle.
- x0 writes: p_we with p_addr=0, and s_valid with s_addr=0. Required: no rf_we from either; the secondary handshake completes and count stays unchanged.
- Scoreboard (macro defined): sb_set x9, then rd_addr1=9. Required: busy1=1 until the secondary write to x9 reaches rf_we, then 0. A same-cycle set and clear of x9 leaves busy1=1.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// rv_rf_pkg: shared definitions for the register-file write-port arbiter.
//   RF_WIDTH / RF_ADDR_W  default data and register-address widths
//   REG_X0                hard-wired zero register; writes to it are discarded
//   RF_STARVE_MAX         default starvation limit for queued secondary writes
//   wb_req_t              one pending writeback {addr, data}
package rv_rf_pkg;

  localparam int unsigned RF_WIDTH      = 32;
  localparam int unsigned RF_ADDR_W     = 5;
  localparam int unsigned REG_X0        = 0;
  localparam int unsigned RF_STARVE_MAX = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_WIDTH-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO of writeback requests with an occupancy count.
// Ports:
//   clk, areset     clock, asynchronous active-low reset (FIFO empties)
//   push_i, data_i  enqueue one entry (ignored when full)
//   pop_i           dequeue the head (ignored when empty)
//   data_o          current head entry (undefined while empty)
//   empty_o, full_o occupancy flags
//   count_o         number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
  import rv_rf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         req_t = wb_req_t
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       push_i,
  input  req_t                       data_i,
  input  logic                       pop_i,
  output req_t                       data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  req_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// pipeline writeback (primary, always wins unless stalled) and a long-latency
// unit (secondary, queued and drained into idle write cycles). A starvation
// counter stalls the pipeline for one cycle once the queue head has waited
// STARVE_MAX cycles.
// Ports:
//   clk, areset                 clock, asynchronous active-low reset
//   p_we_i/p_addr_i/p_data_i    primary writeback request
//   p_stall_o                   primary must hold its writeback this cycle
//   s_valid_i/s_ready_o         secondary handshake; s_addr_i/s_data_i payload
//   rf_we_o/rf_addr_o/rf_wdata_o  registered register-file write port
//   sb_set_i/sb_set_addr_i      mark a register as awaiting a secondary write
//   rd_addr1_i/rd_addr2_i       decode source registers; busy1_o/busy2_o flags
// Build option: define RF_ARB_SCOREBOARD_EN to compile in the pending-write
// scoreboard; otherwise busy1_o/busy2_o are tied low and sb/rd inputs ignored.
module rf_write_arbiter
  import rv_rf_pkg::*;
#(
  parameter int unsigned WIDTH      = RF_WIDTH,
  parameter int unsigned ADDR_W     = RF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = RF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              p_we_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [WIDTH-1:0]  p_data_i,
  output logic              p_stall_o,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic [WIDTH-1:0]  s_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [WIDTH-1:0]  rf_wdata_o,
  input  logic              sb_set_i,
  input  logic [ADDR_W-1:0] sb_set_addr_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] AddrX0 = ADDR_W'(REG_X0);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } req_t;

  req_t            push_req, head;
  logic            fifo_push, fifo_empty, fifo_full;
  logic [CntW-1:0] fifo_count;

  logic            p_valid, prim_grant, sec_grant;
  logic [StW-1:0]  starve_q, starve_d;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0]  rf_wdata_q, rf_wdata_d;

  // ---------------------------------------------------------------------------
  // Secondary queue
  // ---------------------------------------------------------------------------
  // Ready depends only on occupancy, never on a same-cycle pop.
  assign s_ready_o = (fifo_count < CntW'(FIFO_DEPTH));
  // x0 results complete the handshake but are dropped without a push.
  assign fifo_push = s_valid_i & s_ready_o & (s_addr_i != AddrX0);
  assign push_req  = '{addr: s_addr_i, data: s_data_i};

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .req_t (req_t)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .push_i  (fifo_push),
    .data_i  (push_req),
    .pop_i   (sec_grant),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign p_stall_o  = (starve_q == StW'(STARVE_MAX)) & ~fifo_empty;
  assign p_valid    = p_we_i & (p_addr_i != AddrX0);
  assign sec_grant  = ~fifo_empty & (p_stall_o | ~p_valid);
  assign prim_grant = p_valid & ~p_stall_o;

  always_comb begin
    starve_d = starve_q;
    if (sec_grant || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != StW'(STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Address/data hold their last value on idle cycles; only rf_we qualifies them.
  always_comb begin
    rf_we_d    = sec_grant | prim_grant;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    if (sec_grant) begin
      rf_addr_d  = head.addr;
      rf_wdata_d = head.data;
    end else if (prim_grant) begin
      rf_addr_d  = p_addr_i;
      rf_wdata_d = p_data_i;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_addr_o  = rf_addr_q;
  assign rf_wdata_o = rf_wdata_q;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------------
`ifdef RF_ARB_SCOREBOARD_EN
  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NumRegs-1:0] pend_q, pend_d;

  // Clear on the edge that launches the secondary write; a set to the same
  // register in that cycle is applied afterwards and therefore wins.
  always_comb begin
    pend_d = pend_q;
    if (sec_grant) pend_d[head.addr] = 1'b0;
    if (sb_set_i && (sb_set_addr_i != AddrX0)) pend_d[sb_set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign busy1_o = pend_q[rd_addr1_i];
  assign busy2_o = pend_q[rd_addr2_i];
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set_i, sb_set_addr_i, rd_addr1_i, rd_addr2_i};
  assign busy1_o   = 1'b0;
  assign busy2_o   = 1'b0;
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a queue-based model of the port
// sharing rules is checked every cycle, with hand-computed directed checks.
module tb_rf_write_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 2;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic          p_we, s_valid, sb_set;
  logic [AW-1:0] p_addr, s_addr, sb_set_addr, rd_addr1, rd_addr2;
  logic [W-1:0]  p_data, s_data;
  logic          p_stall, s_ready, rf_we, busy1, busy2;
  logic [AW-1:0] rf_addr;
  logic [W-1:0]  rf_wdata;

  rf_write_arbiter dut (
    .clk           (clk),
    .areset        (areset),
    .p_we_i        (p_we),
    .p_addr_i      (p_addr),
    .p_data_i      (p_data),
    .p_stall_o     (p_stall),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .s_addr_i      (s_addr),
    .s_data_i      (s_data),
    .rf_we_o       (rf_we),
    .rf_addr_o     (rf_addr),
    .rf_wdata_o    (rf_wdata),
    .sb_set_i      (sb_set),
    .sb_set_addr_i (sb_set_addr),
    .rd_addr1_i    (rd_addr1),
    .rd_addr2_i    (rd_addr2),
    .busy1_o       (busy1),
    .busy2_o       (busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: pending secondary writes in arrival order, how long the head
  // has waited, and which registers still await a secondary write.
  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } ent_t;

  ent_t          q[$];
  int            wait_n = 0;
  bit            pend[32];
  bit            exp_we;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_data;

  task automatic model_clear();
    q.delete();
    wait_n = 0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
  endtask

  // One clock cycle: inputs were set just after a falling edge.
  task automatic step();
    bit stall, rdy, pv, sg, pg;
    ent_t e;
    #1;
    stall = (wait_n >= SM) && (q.size() > 0);
    rdy   = q.size() < D;
    chk("p_stall", p_stall, stall);
    chk("s_ready", s_ready, rdy);
    chk("busy1", busy1, pend[rd_addr1]);
    chk("busy2", busy2, pend[rd_addr2]);
    pv = p_we && (p_addr != 0);
    sg = (q.size() > 0) && (stall || !pv);
    pg = pv && !stall;
    exp_we = sg || pg;
    if (sg) begin
      e = q.pop_front();
      exp_addr = e.a;
      exp_data = e.d;
      pend[e.a] = 1'b0;
      wait_n = 0;
    end else begin
      if (pg) begin
        exp_addr = p_addr;
        exp_data = p_data;
      end
      if (q.size() == 0) wait_n = 0;
      else if (wait_n < SM) wait_n++;
    end
    if (s_valid && rdy && (s_addr != 0)) begin
      e.a = s_addr;
      e.d = s_data;
      q.push_back(e);
    end
`ifdef RF_ARB_SCOREBOARD_EN
    if (sb_set && (sb_set_addr != 0)) pend[sb_set_addr] = 1'b1;
`endif
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, exp_we);
    if (exp_we) begin
      chk("rf_addr", rf_addr, exp_addr);
      chk("rf_wdata", rf_wdata, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic pw, input logic [AW-1:0] pa, input logic [W-1:0] pd,
                       input logic sv, input logic [AW-1:0] sa, input logic [W-1:0] sd);
    p_we = pw; p_addr = pa; p_data = pd;
    s_valid = sv; s_addr = sa; s_data = sd;
    step();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_we"}, rf_we, 1'b0);
    chk({tag, "_rf_addr"}, rf_addr, '0);
    chk({tag, "_rf_wdata"}, rf_wdata, '0);
    chk({tag, "_s_ready"}, s_ready, 1'b1);
    chk({tag, "_p_stall"}, p_stall, 1'b0);
    chk({tag, "_busy1"}, busy1, 1'b0);
    chk({tag, "_busy2"}, busy2, 1'b0);
  endtask

  initial begin
    areset = 1'b0;
    p_we = 0; p_addr = '0; p_data = '0;
    s_valid = 0; s_addr = '0; s_data = '0;
    sb_set = 0; sb_set_addr = '0; rd_addr1 = 5'd9; rd_addr2 = 5'd7;
    model_clear();
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    areset = 1'b1;

    // Idle drain: push at edge N, write visible after edge N+1.
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("drain_not_yet", rf_we, 1'b0);
    idle();
    chk("drain_we", rf_we, 1'b1);
    chk("drain_addr", rf_addr, 5'd5);
    chk("drain_data", rf_wdata, 32'hDEAD_BEEF);
    idle();

    // Priority: primary x3 and queue head x7 compete in the same cycle.
    drive(1'b1, 5'd2, 32'h5, 1'b1, 5'd7, 32'h22);
    drive(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
    chk("prio_first_addr", rf_addr, 5'd3);
    chk("prio_first_data", rf_wdata, 32'h11);
    idle();
    chk("prio_second_we", rf_we, 1'b1);
    chk("prio_second_addr", rf_addr, 5'd7);
    chk("prio_second_data", rf_wdata, 32'h22);
    idle();

    // Backpressure and starvation under continuous primary traffic.
    for (int i = 0; i < 12; i++) begin
      p_we = 1'b1; p_addr = 5'(i + 1); p_data = 32'h100 + 32'(i);
      s_valid = (i < 2); s_addr = 5'(20 + i); s_data = 32'hA0 + 32'(i);
      #1;
      chk("starve_p_stall", p_stall, (i == 5 || i == 10));
      if (i == 2) chk("full_s_ready", s_ready, 1'b0);
      if (i == 6) chk("after_pop_s_ready", s_ready, 1'b1);
      step();
      if (i == 5) chk("forced_addr", rf_addr, 5'd20);
      if (i == 10) chk("forced2_addr", rf_addr, 5'd21);
    end
    idle();

    // x0 writes: neither source reaches the port and nothing is queued.
    for (int i = 0; i < 3; i++) begin
      p_we = 1'b1; p_addr = '0; p_data = 32'hFFFF;
      s_valid = 1'b1; s_addr = '0; s_data = 32'hEEEE;
      #1;
      chk("x0_s_ready", s_ready, 1'b1);
      step();
      chk("x0_rf_we", rf_we, 1'b0);
    end
    idle();
    chk("x0_nothing_queued", rf_we, 1'b0);

    // Reset mid-stream with two entries queued.
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'hB0);
    drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd11, 32'hB1);
    p_we = 0; s_valid = 0;
    areset = 1'b0;
    #1;
    chk_reset_outputs("mid");
    model_clear();
    @(negedge clk);
    areset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("lost_after_reset", rf_we, 1'b0);
    end

`ifdef RF_ARB_SCOREBOARD_EN
    rd_addr1 = 5'd9;
    sb_set = 1'b1; sb_set_addr = 5'd9;
    idle();
    sb_set = 1'b0;
    #1;
    chk("sb_busy_set", busy1, 1'b1);
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99);
    chk("sb_busy_queued", busy1, 1'b1);
    sb_set = 1'b1; sb_set_addr = 5'd9;
    idle();
    sb_set = 1'b0;
    chk("sb_collide_we", rf_addr, 5'd9);
    chk("sb_set_wins", busy1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h9A);
    chk("sb_still_busy", busy1, 1'b1);
    idle();
    chk("sb_clear_we", rf_we, 1'b1);
    chk("sb_cleared", busy1, 1'b0);
    idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
